// File: rtl/rx_audio_memory.sv
// ----------------------------------------------------------------------------
// rx_audio_memory
//
// Double-buffered receive sample memory sitting between the per-channel RX
// serializers and the CPU command interface.
//
// Each rx_avail pulse starts a fetch of one 24-bit I/Q sample from every RX
// channel. The shared strobes rd_getI, rd_getQ and ser are issued per channel
// and give the words I[23:8], Q[23:8] and {I[7:0],Q[7:0]}. Every strobe
// returns one 16-bit word on that channel's lane of rxn_din one cycle later,
// and that word is written into the active buffer. When a buffer holds
// nrx_samps samples, the 48-bit timestamp that was latched at the first sample
// is appended as three words. The buffer is then handed to the CPU through a
// service request, and capture continues in the other buffer.
//
// Ports
//   adc_clk      sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   nrx_samps    samples per buffer, sampled at buffer start (0 acts as 1)
//   rx_avail     1-cycle pulse: a new sample is ready in every channel
//   rxn_din      channel c word on [c*16 +: 16], valid 1 cycle after a strobe
//   ticks        free-running timestamp
//   rd_getI      fetch strobe for I[23:8]
//   rd_getQ      fetch strobe for Q[23:8]
//   ser          fetch strobe for {I[7:0],Q[7:0]}
//   get_rx_srq   CPU command: read {14'b0, overrun, srq}
//   get_rx_samp  CPU command: read the next word of the completed buffer
//   reset_bufs   CPU command: abort capture and clear all buffer state
//   get_buf_ctr  CPU command: read the completed-buffer counter
//   rx_rd        1-cycle pulse: rx_dout carries the answer to a read command
//   rx_dout      CPU read data, held until the next read command
// ----------------------------------------------------------------------------
module rx_audio_memory #(
    parameter int V_RX_CHANS = 4,
    parameter int MAX_SAMPS  = 1024
) (
    input  logic                      adc_clk,
    input  logic                      rst_n,
    input  logic [9:0]                nrx_samps,
    input  logic                      rx_avail,
    input  logic [V_RX_CHANS*16-1:0]  rxn_din,
    input  logic [47:0]               ticks,
    output logic                      rd_getI,
    output logic                      rd_getQ,
    output logic                      ser,
    input  logic                      get_rx_srq,
    input  logic                      get_rx_samp,
    input  logic                      reset_bufs,
    input  logic                      get_buf_ctr,
    output logic                      rx_rd,
    output logic [15:0]               rx_dout
);

    // Memory geometry: two buffers of MAX_SAMPS samples plus 3 timestamp words.
    localparam int BUF_WORDS = MAX_SAMPS * V_RX_CHANS * 3 + 3;
    localparam int MEM_WORDS = 2 * BUF_WORDS;
    localparam int AW        = $clog2(MEM_WORDS);
    localparam int STEPS     = 3 * V_RX_CHANS;
    localparam int SW        = $clog2(STEPS + 1);
    localparam int CW        = (V_RX_CHANS > 1) ? $clog2(V_RX_CHANS) : 1;

    localparam logic [AW-1:0] SAMP_STRIDE = AW'(STEPS);
    localparam logic [AW-1:0] BUF1_BASE   = AW'(BUF_WORDS);
    localparam logic [SW-1:0] LAST_STEP   = SW'(STEPS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_TICKS = 2'd2;

    // Capture state
    logic [1:0]    r_state;
    logic [SW-1:0] r_step;
    logic [1:0]    r_k;
    logic [CW-1:0] r_chan;
    logic [9:0]    r_samp;
    logic [9:0]    r_nSamps;
    logic [AW-1:0] r_sampBase;
    logic [1:0]    r_tickStep;
    logic [47:0]   r_ticks;
    logic          r_wrBuf;

    // Write pipeline: one stage between a strobe and its returning data
    logic          r_wrValid;
    logic [AW-1:0] r_wrAddr;
    logic [CW-1:0] r_wrChan;

    // Status and read side
    logic          r_srq;
    logic          r_overrun;
    logic [15:0]   r_bufCtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW-1:0] r_rdLast;
    logic          r_rxRd;
    logic          r_doutSel;
    logic [15:0]   r_doutReg;
    logic [15:0]   r_memQ;

    logic [15:0]   r_mem [0:MEM_WORDS-1];

    logic          w_cmdReset;
    logic          w_cmdSamp;
    logic          w_cmdSrq;
    logic          w_cmdCtr;
    logic [AW-1:0] w_bufBase;
    logic [9:0]    w_sampNext;
    logic [9:0]    w_nSampsIn;
    logic          w_tickWrite;
    logic          w_tickDone;
    logic [15:0]   w_chanData;
    logic [15:0]   w_tickData;
    logic          w_memWe;
    logic [AW-1:0] w_memAddr;
    logic [15:0]   w_memData;

    // CPU command decode with a fixed priority: lower-priority commands that
    // arrive together with a higher one are dropped.
    assign w_cmdReset = reset_bufs;
    assign w_cmdSamp  = get_rx_samp & ~reset_bufs;
    assign w_cmdSrq   = get_rx_srq  & ~reset_bufs & ~get_rx_samp;
    assign w_cmdCtr   = get_buf_ctr & ~reset_bufs & ~get_rx_samp & ~get_rx_srq;

    assign w_bufBase  = r_wrBuf ? BUF1_BASE : '0;
    assign w_sampNext = r_samp + 10'd1;
    assign w_nSampsIn = (nrx_samps == 10'd0) ? 10'd1 : nrx_samps;

    // The first TICKS cycle only lets the final sample word drain through the
    // write pipeline. The three timestamp words follow in steps 1..3.
    assign w_tickWrite = (r_state == ST_TICKS) && (r_tickStep != 2'd0);
    assign w_tickDone  = (r_state == ST_TICKS) && (r_tickStep == 2'd3);

    // The strobes are shared by all channels and decoded from the word phase.
    assign rd_getI = (r_state == ST_FETCH) && (r_k == 2'd0);
    assign rd_getQ = (r_state == ST_FETCH) && (r_k == 2'd1);
    assign ser     = (r_state == ST_FETCH) && (r_k == 2'd2);

    // Select the lane of the channel whose strobe went out last cycle.
    always_comb begin
        w_chanData = rxn_din[15:0];
        for (int c = 0; c < V_RX_CHANS; c++) begin
            if (r_wrChan == CW'(c)) begin
                w_chanData = rxn_din[c*16 +: 16];
            end
        end
    end

    always_comb begin
        case (r_tickStep)
            2'd1:    w_tickData = r_ticks[47:32];
            2'd2:    w_tickData = r_ticks[31:16];
            default: w_tickData = r_ticks[15:0];
        endcase
    end

    // Single write port. Sample words and timestamp words never share a
    // cycle. A reset_bufs command suppresses any write still in flight.
    assign w_memWe   = (r_wrValid | w_tickWrite) & ~w_cmdReset;
    assign w_memAddr = w_tickWrite ? (w_bufBase + r_sampBase + AW'(r_tickStep - 2'd1))
                                   : r_wrAddr;
    assign w_memData = w_tickWrite ? w_tickData : w_chanData;

    // The sample RAM has no reset so that it can map onto block memory.
    always_ff @(posedge adc_clk) begin
        if (w_memWe) begin
            r_mem[w_memAddr] <= w_memData;
        end
        if (w_cmdSamp) begin
            r_memQ <= r_mem[r_rdPtr];
        end
    end

    // Capture sequencer. A sample fetch walks r_step through 3*V_RX_CHANS
    // strobes, so r_step equals the word offset 3c+k within the sample.
    // r_sampBase tracks samp*3*V_RX_CHANS so that no multiplier is needed.
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_step     <= '0;
            r_k        <= 2'd0;
            r_chan     <= '0;
            r_samp     <= 10'd0;
            r_nSamps   <= 10'd1;
            r_sampBase <= '0;
            r_tickStep <= 2'd0;
            r_ticks    <= 48'd0;
            r_wrBuf    <= 1'b0;
            r_wrValid  <= 1'b0;
            r_wrAddr   <= '0;
            r_wrChan   <= '0;
        end else if (w_cmdReset) begin
            r_state    <= ST_IDLE;
            r_step     <= '0;
            r_k        <= 2'd0;
            r_chan     <= '0;
            r_samp     <= 10'd0;
            r_sampBase <= '0;
            r_tickStep <= 2'd0;
            r_wrBuf    <= 1'b0;
            r_wrValid  <= 1'b0;
        end else begin
            r_wrValid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_avail) begin
                        r_state <= ST_FETCH;
                        r_step  <= '0;
                        r_k     <= 2'd0;
                        r_chan  <= '0;
                        // Timestamp and length belong to the buffer as a
                        // whole, so both are taken at its first sample.
                        if (r_samp == 10'd0) begin
                            r_ticks  <= ticks;
                            r_nSamps <= w_nSampsIn;
                        end
                    end
                end
                ST_FETCH: begin
                    r_wrValid <= 1'b1;
                    r_wrAddr  <= w_bufBase + r_sampBase + AW'(r_step);
                    r_wrChan  <= r_chan;
                    if (r_step == LAST_STEP) begin
                        r_step     <= '0;
                        r_k        <= 2'd0;
                        r_chan     <= '0;
                        r_samp     <= w_sampNext;
                        r_sampBase <= r_sampBase + SAMP_STRIDE;
                        if (w_sampNext == r_nSamps) begin
                            r_state    <= ST_TICKS;
                            r_tickStep <= 2'd0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_step <= r_step + SW'(1);
                        if (r_k == 2'd2) begin
                            r_k    <= 2'd0;
                            r_chan <= r_chan + CW'(1);
                        end else begin
                            r_k <= r_k + 2'd1;
                        end
                    end
                end
                ST_TICKS: begin
                    if (r_tickStep == 2'd3) begin
                        r_state    <= ST_IDLE;
                        r_tickStep <= 2'd0;
                        r_wrBuf    <= ~r_wrBuf;
                        r_samp     <= 10'd0;
                        r_sampBase <= '0;
                    end else begin
                        r_tickStep <= r_tickStep + 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Service-request status and the CPU read pointer. Completion of a
    // buffer takes precedence over a read in the same cycle, because it
    // re-targets the read pointer at the freshly finished buffer.
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_srq     <= 1'b0;
            r_overrun <= 1'b0;
            r_bufCtr  <= 16'd0;
            r_rdPtr   <= '0;
            r_rdLast  <= '0;
        end else if (w_cmdReset) begin
            r_srq     <= 1'b0;
            r_overrun <= 1'b0;
            r_bufCtr  <= 16'd0;
            r_rdPtr   <= '0;
            r_rdLast  <= '0;
        end else begin
            if (rx_avail && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (w_tickDone) begin
                r_bufCtr <= r_bufCtr + 16'd1;
                r_srq    <= 1'b1;
                if (r_srq) begin
                    r_overrun <= 1'b1;
                end
                r_rdPtr  <= w_bufBase;
                r_rdLast <= w_bufBase + r_sampBase + AW'(2);
            end else if (w_cmdSamp) begin
                r_rdPtr <= r_rdPtr + AW'(1);
                if (r_rdPtr == r_rdLast) begin
                    r_srq <= 1'b0;
                end
            end
        end
    end

    // Read response. Sample data comes straight from the RAM output register.
    // Status and counter answers go through r_doutReg. The select bit keeps
    // rx_dout stable until the next read command.
    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxRd    <= 1'b0;
            r_doutSel <= 1'b0;
            r_doutReg <= 16'd0;
        end else begin
            r_rxRd <= w_cmdSamp | w_cmdSrq | w_cmdCtr;
            if (w_cmdSamp) begin
                r_doutSel <= 1'b1;
            end else if (w_cmdSrq) begin
                r_doutSel <= 1'b0;
                r_doutReg <= {14'b0, r_overrun, r_srq};
            end else if (w_cmdCtr) begin
                r_doutSel <= 1'b0;
                r_doutReg <= r_bufCtr;
            end
        end
    end

    assign rx_rd   = r_rxRd;
    assign rx_dout = r_doutSel ? r_memQ : r_doutReg;

endmodule

// File: tb/tb_rx_audio_memory.sv
// ----------------------------------------------------------------------------
// tb_rx_audio_memory
//
// Directed bench for rx_audio_memory with 4 channels. Inputs change on the
// falling edge and outputs are sampled there, half a cycle away from the
// active edge. The channel data lanes follow a pattern derived from the bench
// cycle index, so every captured word can be predicted from the cycle of its
// rx_avail pulse alone.
// ----------------------------------------------------------------------------
module tb_rx_audio_memory;

    localparam int NCH   = 4;
    localparam int STEPS = 3 * NCH;

    logic              adc_clk = 1'b0;
    logic              rst_n   = 1'b1;
    logic [9:0]        nrx_samps;
    logic              rx_avail;
    logic [NCH*16-1:0] rxn_din;
    logic [47:0]       ticks;
    logic              rd_getI;
    logic              rd_getQ;
    logic              ser;
    logic              get_rx_srq;
    logic              get_rx_samp;
    logic              reset_bufs;
    logic              get_buf_ctr;
    logic              rx_rd;
    logic [15:0]       rx_dout;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    logic [15:0] expWords [$];

    rx_audio_memory #(
        .V_RX_CHANS (NCH),
        .MAX_SAMPS  (1024)
    ) dut (
        .adc_clk     (adc_clk),
        .rst_n       (rst_n),
        .nrx_samps   (nrx_samps),
        .rx_avail    (rx_avail),
        .rxn_din     (rxn_din),
        .ticks       (ticks),
        .rd_getI     (rd_getI),
        .rd_getQ     (rd_getQ),
        .ser         (ser),
        .get_rx_srq  (get_rx_srq),
        .get_rx_samp (get_rx_samp),
        .reset_bufs  (reset_bufs),
        .get_buf_ctr (get_buf_ctr),
        .rx_rd       (rx_rd),
        .rx_dout     (rx_dout)
    );

    always #5 adc_clk = ~adc_clk;

    // Lane pattern for cycle x and channel c.
    function automatic logic [15:0] pat(input int x, input int c);
        return 16'(x * 16 + c);
    endfunction

    task automatic checkOutput(input string tag, input logic [47:0] actual,
                               input logic [47:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Advance to the next falling edge, refresh the data lanes for the new
    // cycle and drop every pulse input.
    task automatic applyStimulus();
        @(negedge adc_clk);
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            rxn_din[c*16 +: 16] = pat(cyc, c);
        end
        rx_avail    = 1'b0;
        get_rx_srq  = 1'b0;
        get_rx_samp = 1'b0;
        reset_bufs  = 1'b0;
        get_buf_ctr = 1'b0;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) applyStimulus();
    endtask

    // Pulse rx_avail, check the I,Q,ser strobe order for every channel and
    // queue the words that this sample is expected to leave in memory.
    task automatic startSample(output int t);
        logic [2:0] expStrobe;
        applyStimulus();
        rx_avail = 1'b1;
        t = cyc;
        for (int j = 0; j < STEPS; j++) begin
            applyStimulus();
            expStrobe = (j % 3 == 0) ? 3'b100 : ((j % 3 == 1) ? 3'b010 : 3'b001);
            checkOutput($sformatf("strobe%0d", j), 48'({rd_getI, rd_getQ, ser}),
                        48'(expStrobe));
            expWords.push_back(pat(t + 2 + j, j / 3));
        end
        applyStimulus();
        checkOutput("strobeEnd", 48'({rd_getI, rd_getQ, ser}), 48'(0));
    endtask

    // kind: 0 = get_rx_srq, 1 = get_buf_ctr
    task automatic cpuRead(input int kind, input string tag, input logic [15:0] expv);
        applyStimulus();
        if (kind == 0) get_rx_srq = 1'b1;
        else           get_buf_ctr = 1'b1;
        checkOutput({tag, "_rdBefore"}, 48'(rx_rd), 48'(0));
        applyStimulus();
        checkOutput({tag, "_rd"}, 48'(rx_rd), 48'(1));
        checkOutput(tag, 48'(rx_dout), 48'(expv));
    endtask

    // Back-to-back get_rx_samp over the queued words.
    task automatic readBuffer(input string tag);
        int n;
        n = expWords.size();
        for (int i = 0; i <= n; i++) begin
            applyStimulus();
            if (i > 0) begin
                checkOutput($sformatf("%s_rd%0d", tag, i - 1), 48'(rx_rd), 48'(1));
                checkOutput($sformatf("%s_word%0d", tag, i - 1), 48'(rx_dout),
                            48'(expWords[i-1]));
            end
            if (i < n) get_rx_samp = 1'b1;
        end
        expWords.delete();
    endtask

    task automatic pulseResetBufs();
        applyStimulus();
        reset_bufs = 1'b1;
        applyStimulus();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0, t1, t2, t3, t4, t5, t6;
        logic [2:0] seen;

        nrx_samps   = 10'd2;
        ticks       = 48'h0123_4567_8ABC;
        rx_avail    = 1'b0;
        rxn_din     = '0;
        get_rx_srq  = 1'b0;
        get_rx_samp = 1'b0;
        reset_bufs  = 1'b0;
        get_buf_ctr = 1'b0;

        #1 rst_n = 1'b0;
        repeat (3) applyStimulus();
        checkOutput("rstStrobes", 48'({rd_getI, rd_getQ, ser}), 48'(0));
        checkOutput("rstRxRd", 48'(rx_rd), 48'(0));
        checkOutput("rstDout", 48'(rx_dout), 48'(0));
        rst_n = 1'b1;
        applyStimulus();
        cpuRead(0, "rstSrq", 16'h0000);
        cpuRead(1, "rstCtr", 16'h0000);

        // Two samples, 20 cycles apart, fill buffer 0. The timestamp is
        // changed after the first sample and must not be used.
        $display("[TB] two-sample buffer");
        startSample(t0);
        ticks = 48'hFFFF_FFFF_FFFF;
        waitUntil(t0 + 15);
        cpuRead(0, "srqBefore", 16'h0000);
        waitUntil(t0 + 19);
        startSample(t1);
        checkOutput("spacing", 48'(t1 - t0), 48'(20));
        expWords.push_back(16'h0123);
        expWords.push_back(16'h4567);
        expWords.push_back(16'h8ABC);
        waitUntil(t1 + 20);
        cpuRead(0, "srqDone", 16'h0001);
        cpuRead(1, "ctrOne", 16'h0001);
        readBuffer("buf0");
        cpuRead(0, "srqCleared", 16'h0000);

        // A pulse 5 cycles after the previous one is dropped and flags overrun.
        $display("[TB] dropped rx_avail");
        pulseResetBufs();
        cpuRead(1, "ctrAfterReset", 16'h0000);
        applyStimulus();
        rx_avail = 1'b1;
        t2 = cyc;
        waitUntil(t2 + 5);
        rx_avail = 1'b1;
        applyStimulus();
        checkOutput("dropNoRestart", 48'({rd_getI, rd_getQ, ser}), 48'(3'b001));
        waitUntil(t2 + 25);
        cpuRead(0, "dropOverrun", 16'h0002);
        expWords.delete();

        // Two buffers complete unread. nrx_samps = 0 acts as one sample.
        $display("[TB] two buffers without reads");
        pulseResetBufs();
        nrx_samps = 10'd0;
        ticks = 48'hAAAA_BBBB_CCCC;
        startSample(t2);
        expWords.delete();
        waitUntil(t2 + 19);
        ticks = 48'h1111_2222_3333;
        startSample(t3);
        ticks = 48'h0;
        expWords.push_back(16'h1111);
        expWords.push_back(16'h2222);
        expWords.push_back(16'h3333);
        waitUntil(t3 + 20);
        cpuRead(1, "ctrTwo", 16'h0002);
        cpuRead(0, "srqOverrun", 16'h0003);
        readBuffer("buf1");
        cpuRead(0, "overrunSticky", 16'h0002);

        // reset_bufs in the middle of a fetch aborts it.
        $display("[TB] reset_bufs mid-fetch");
        nrx_samps = 10'd1;
        applyStimulus();
        rx_avail = 1'b1;
        t4 = cyc;
        waitUntil(t4 + 4);
        checkOutput("abortBefore", 48'({rd_getI, rd_getQ, ser}), 48'(3'b100));
        reset_bufs = 1'b1;
        applyStimulus();
        checkOutput("abortNextCycle", 48'({rd_getI, rd_getQ, ser}), 48'(0));
        seen = 3'b000;
        for (int i = 0; i < 16; i++) begin
            applyStimulus();
            seen = seen | {rd_getI, rd_getQ, ser};
        end
        checkOutput("abortQuiet", 48'(seen), 48'(0));
        cpuRead(1, "abortCtr", 16'h0000);
        cpuRead(0, "abortSrq", 16'h0000);
        ticks = 48'h0F0F_1E1E_2D2D;
        startSample(t5);
        expWords.push_back(16'h0F0F);
        expWords.push_back(16'h1E1E);
        expWords.push_back(16'h2D2D);
        waitUntil(t5 + 20);
        cpuRead(0, "restartSrq", 16'h0001);
        cpuRead(1, "restartCtr", 16'h0001);
        readBuffer("restart");

        // Asynchronous reset in the middle of a capture clears outputs at once.
        $display("[TB] async reset mid-capture");
        applyStimulus();
        rx_avail = 1'b1;
        t6 = cyc;
        waitUntil(t6 + 3);
        checkOutput("asyncBefore", 48'({rd_getI, rd_getQ, ser}), 48'(3'b001));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncStrobes", 48'({rd_getI, rd_getQ, ser}), 48'(0));
        checkOutput("asyncRxRd", 48'(rx_rd), 48'(0));
        checkOutput("asyncDout", 48'(rx_dout), 48'(0));
        repeat (2) applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
        cpuRead(1, "asyncCtr", 16'h0000);
        cpuRead(0, "asyncSrq", 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
